// File: rtl/counter_drv_pkg.sv
// Shared types and default widths for the counter command driver.
package counter_drv_pkg;

    localparam int unsigned CNT_WIDTH = 4;
    localparam int unsigned CNT_LEN_W = 4;

    typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_UP, OP_DOWN} cnt_op_e;
    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, RESP} drv_state_e;

endpackage

// File: rtl/counter_cmd_driver_if.sv
// Command and response channels between a stimulus source and the counter driver.
interface counter_cmd_driver_if
    import counter_drv_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH,
    parameter int unsigned LEN_W = CNT_LEN_W
);
    logic             cmd_valid;
    logic             cmd_ready;
    cnt_op_e          cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_count;
    logic             rsp_high;
    logic             rsp_low;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_len, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_count, rsp_high, rsp_low, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_len, rsp_ready,
        output cmd_ready, rsp_valid, rsp_count, rsp_high, rsp_low, rsp_err
    );
endinterface

// File: rtl/counter_shadow_model.sv
// Reference copy of the saturating up/down counter, fed by the same strobes the
// driver puts on the pins, so its value is what the real counter should show.
module counter_shadow_model
    import counter_drv_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_up,
    input  logic             i_down,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_exp_count,
    output logic             o_exp_high,
    output logic             o_exp_low
);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;
    logic             r_high;
    logic             r_low;
    logic [WIDTH-1:0] w_next;

    // load > up > down, both directions saturate
    always_comb begin
        w_next = r_count;
        if (i_load) begin
            w_next = i_in;
        end else if (i_up) begin
            if (r_count != CNT_MAX) w_next = r_count + WIDTH'(1);
        end else if (i_down) begin
            if (r_count != '0) w_next = r_count - WIDTH'(1);
        end
    end

    // flags track the registered value, so low is set while held at zero in reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_high  <= 1'b0;
            r_low   <= 1'b1;
        end else begin
            r_count <= w_next;
            r_high  <= (w_next == CNT_MAX);
            r_low   <= (w_next == '0);
        end
    end

    assign o_exp_count = r_count;
    assign o_exp_high  = r_high;
    assign o_exp_low   = r_low;
endmodule

// File: rtl/counter_cmd_driver.sv
// Turns valid/ready commands into counter pin strobes, then returns the sampled
// counter state with a pass/fail flag from the shadow model.
module counter_cmd_driver
    import counter_drv_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH,
    parameter int unsigned LEN_W = CNT_LEN_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    counter_cmd_driver_if.slave  io_bus,
    output logic                 o_load,
    output logic                 o_up,
    output logic                 o_down,
    output logic [WIDTH-1:0]     o_in,
    input  logic [WIDTH-1:0]     i_count,
    input  logic                 i_high,
    input  logic                 i_low,
    output logic                 o_err_sticky
);
    drv_state_e       r_state;
    drv_state_e       w_state_nxt;
    cnt_op_e          r_op;
    cnt_op_e          w_op_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic [LEN_W-1:0] r_len_cnt;

    logic             r_cmd_ready, r_rsp_valid, r_load, r_up, r_down;
    logic [WIDTH-1:0] r_in;
    logic             w_cmd_ready_d, w_rsp_valid_d, w_load_d, w_up_d, w_down_d;
    logic [WIDTH-1:0] w_in_d;

    logic [WIDTH-1:0] r_rsp_count;
    logic             r_rsp_high, r_rsp_low, r_rsp_err, r_err_sticky;

    logic [WIDTH-1:0] w_exp_count;
    logic             w_exp_high, w_exp_low;
    logic             w_accept, w_mismatch;

    assign w_accept   = (r_state == IDLE) && io_bus.cmd_valid;
    assign w_mismatch = (i_count != w_exp_count) || (i_high != w_exp_high) || (i_low != w_exp_low);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)             w_state_nxt = DRIVE;
            DRIVE:   if (r_len_cnt == '0)      w_state_nxt = SETTLE;
            SETTLE:                            w_state_nxt = RESP;
            RESP:    if (io_bus.rsp_ready)     w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    // outputs decoded from the next state so the pins switch on the entering edge
    always_comb begin
        w_op_nxt      = w_accept ? io_bus.cmd_op   : r_op;
        w_data_nxt    = w_accept ? io_bus.cmd_data : r_data;
        w_cmd_ready_d = (w_state_nxt == IDLE);
        w_rsp_valid_d = (w_state_nxt == RESP);
        w_load_d      = (w_state_nxt == DRIVE) && (w_op_nxt == OP_LOAD);
        w_up_d        = (w_state_nxt == DRIVE) && (w_op_nxt == OP_UP);
        w_down_d      = (w_state_nxt == DRIVE) && (w_op_nxt == OP_DOWN);
        w_in_d        = w_load_d ? w_data_nxt : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_load      <= 1'b0;
            r_up        <= 1'b0;
            r_down      <= 1'b0;
            r_in        <= '0;
        end else begin
            r_cmd_ready <= w_cmd_ready_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_load      <= w_load_d;
            r_up        <= w_up_d;
            r_down      <= w_down_d;
            r_in        <= w_in_d;
        end
    end

    // command latch, repeat counter and response capture at the end of SETTLE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op         <= OP_HOLD;
            r_data       <= '0;
            r_len_cnt    <= '0;
            r_rsp_count  <= '0;
            r_rsp_high   <= 1'b0;
            r_rsp_low    <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op      <= io_bus.cmd_op;
                r_data    <= io_bus.cmd_data;
                r_len_cnt <= io_bus.cmd_len;
            end else if ((r_state == DRIVE) && (r_len_cnt != '0)) begin
                r_len_cnt <= r_len_cnt - LEN_W'(1);
            end
            if (r_state == SETTLE) begin
                r_rsp_count  <= i_count;
                r_rsp_high   <= i_high;
                r_rsp_low    <= i_low;
                r_rsp_err    <= w_mismatch;
                r_err_sticky <= r_err_sticky | w_mismatch;
            end
        end
    end

    counter_shadow_model #(.WIDTH(WIDTH)) u_shadow (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (r_load),
        .i_up        (r_up),
        .i_down      (r_down),
        .i_in        (r_in),
        .o_exp_count (w_exp_count),
        .o_exp_high  (w_exp_high),
        .o_exp_low   (w_exp_low)
    );

    assign io_bus.cmd_ready = r_cmd_ready;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_count = r_rsp_count;
    assign io_bus.rsp_high  = r_rsp_high;
    assign io_bus.rsp_low   = r_rsp_low;
    assign io_bus.rsp_err   = r_rsp_err;
    assign o_load           = r_load;
    assign o_up             = r_up;
    assign o_down           = r_down;
    assign o_in             = r_in;
    assign o_err_sticky     = r_err_sticky;
endmodule

// File: tb/tb_counter_cmd_driver.sv
// Bench for counter_cmd_driver: counter stub with optional dropped increments,
// a per-command arithmetic model checked every cycle, plus directed literal checks.
module tb_counter_cmd_driver;
    import counter_drv_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       load, up, down, high, low, sticky;
    logic [3:0] in_pins;
    logic [3:0] cnt = 4'd0;
    bit         fault_drop = 1'b0;
    bit         chk_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // model: cycle index since accept plus whole-command results
    int m_k = 0, m_len = 1, m_op = 0, m_data = 0;
    int m_ideal = 0, m_phys = 0, m_rsp = 0;
    bit m_err = 1'b0, m_sticky = 1'b0;

    counter_cmd_driver_if #(.WIDTH(4), .LEN_W(4)) bus ();

    counter_cmd_driver #(.WIDTH(4), .LEN_W(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .io_bus       (bus),
        .o_load       (load),
        .o_up         (up),
        .o_down       (down),
        .o_in         (in_pins),
        .i_count      (cnt),
        .i_high       (high),
        .i_low        (low),
        .o_err_sticky (sticky)
    );

    always #5 clk = ~clk;

    // counter under drive; fault_drop swallows up strobes
    assign high = (cnt == 4'd15);
    assign low  = (cnt == 4'd0);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          cnt <= 4'd0;
        else if (load)                       cnt <= in_pins;
        else if (up) begin
            if (!fault_drop && cnt != 4'd15) cnt <= cnt + 4'd1;
        end else if (down && cnt != 4'd0)    cnt <= cnt - 4'd1;
    end

    function automatic int apply(int op, int v, int data, int n, bit drop_up);
        case (op)
            1:       return data;
            2:       return drop_up ? v : ((v + n > 15) ? 15 : v + n);
            3:       return (v - n < 0) ? 0 : v - n;
            default: return v;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k <= 0; m_len <= 1; m_op <= 0; m_data <= 0;
            m_ideal <= 0; m_phys <= 0; m_rsp <= 0; m_err <= 1'b0; m_sticky <= 1'b0;
        end else if (m_k == 0) begin
            if (bus.cmd_valid) begin
                m_k    <= 1;
                m_len  <= int'(bus.cmd_len) + 1;
                m_op   <= int'(bus.cmd_op);
                m_data <= int'(bus.cmd_data);
                m_ideal <= apply(int'(bus.cmd_op), m_ideal, int'(bus.cmd_data), int'(bus.cmd_len) + 1, 1'b0);
                m_phys  <= apply(int'(bus.cmd_op), m_phys, int'(bus.cmd_data), int'(bus.cmd_len) + 1, fault_drop);
                m_rsp   <= apply(int'(bus.cmd_op), m_phys, int'(bus.cmd_data), int'(bus.cmd_len) + 1, fault_drop);
                m_err   <= apply(int'(bus.cmd_op), m_ideal, int'(bus.cmd_data), int'(bus.cmd_len) + 1, 1'b0) !=
                           apply(int'(bus.cmd_op), m_phys, int'(bus.cmd_data), int'(bus.cmd_len) + 1, fault_drop);
            end
        end else if (m_k <= m_len + 1) begin
            m_k <= m_k + 1;
        end else if (bus.rsp_ready) begin
            m_k      <= 0;
            m_sticky <= m_sticky | m_err;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", int'(bus.cmd_ready), int'(m_k == 0));
            chk("load",  int'(load), int'(m_k >= 1 && m_k <= m_len && m_op == 1));
            chk("up",    int'(up),   int'(m_k >= 1 && m_k <= m_len && m_op == 2));
            chk("down",  int'(down), int'(m_k >= 1 && m_k <= m_len && m_op == 3));
            chk("in",    int'(in_pins), (m_k >= 1 && m_k <= m_len && m_op == 1) ? m_data : 0);
            chk("rsp_valid", int'(bus.rsp_valid), int'(m_k >= m_len + 2));
            chk("err_sticky", int'(sticky), int'(m_sticky || (m_k >= m_len + 2 && m_err)));
            if (m_k >= m_len + 2) begin
                chk("rsp_count", int'(bus.rsp_count), m_rsp);
                chk("rsp_high",  int'(bus.rsp_high), int'(m_rsp == 15));
                chk("rsp_low",   int'(bus.rsp_low),  int'(m_rsp == 0));
                chk("rsp_err",   int'(bus.rsp_err),  int'(m_err));
            end
        end
    end

    // one full command with literal expectations; stall holds rsp_ready low
    task automatic do_cmd(input int op, input int data, input int len, input int stall,
                          input int e_cnt, input int e_high, input int e_low,
                          input int e_err, input int e_sticky);
        int wait_n;
        int lat;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = cnt_op_e'(2'(op));
        bus.cmd_data  = 4'(data);
        bus.cmd_len   = 4'(len);
        wait_n = 0;
        while (!bus.cmd_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (wait_n >= 50) chk("accept_timeout", 0, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_latency", lat, len + 3);
        chk("lit_count", int'(bus.rsp_count), e_cnt);
        chk("lit_high",  int'(bus.rsp_high),  e_high);
        chk("lit_low",   int'(bus.rsp_low),   e_low);
        chk("lit_err",   int'(bus.rsp_err),   e_err);
        chk("lit_sticky", int'(sticky),       e_sticky);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", int'(bus.rsp_valid), 1);
            chk("stall_count", int'(bus.rsp_count), e_cnt);
            chk("stall_ready", int'(bus.cmd_ready), 0);
            chk("stall_pins",  int'(load | up | down), 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("ready_after_rsp", int'(bus.cmd_ready), 1);
        chk("valid_after_rsp", int'(bus.rsp_valid), 0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_HOLD;
        bus.cmd_data  = 4'd0;
        bus.cmd_len   = 4'd0;
        bus.rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_cmd(1, 9, 0, 0,   9, 0, 0, 0, 0);   // LOAD 9, single strobe
        do_cmd(2, 0, 7, 0,  15, 1, 0, 0, 0);   // UP x8 saturates at 15
        do_cmd(3, 0, 15, 0,  0, 0, 1, 0, 0);   // DOWN x16 to zero
        do_cmd(3, 0, 0, 0,   0, 0, 1, 0, 0);   // DOWN at zero holds
        do_cmd(2, 0, 2, 0,   3, 0, 0, 0, 0);
        do_cmd(0, 0, 3, 0,   3, 0, 0, 0, 0);   // HOLD leaves count
        do_cmd(1, 15, 1, 0, 15, 1, 0, 0, 0);
        do_cmd(2, 0, 0, 0,  15, 1, 0, 0, 0);   // UP at max holds

        do_cmd(1, 5, 0, 0,   5, 0, 0, 0, 0);
        fault_drop = 1'b1;
        do_cmd(2, 0, 0, 0,   5, 0, 0, 1, 1);   // dropped increment flagged
        fault_drop = 1'b0;
        do_cmd(1, 3, 0, 0,   3, 0, 0, 0, 1);
        do_cmd(2, 0, 15, 5, 15, 1, 0, 0, 1);   // stalled response

        // reset in the third drive cycle of UP len=10
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_UP;
        bus.cmd_len   = 4'd10;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_up", int'(up), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_up_now", int'(up), 0);
        chk("rst_ready_now", int'(bus.cmd_ready), 1);
        chk("rst_sticky_now", int'(sticky), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_valid", int'(bus.rsp_valid), 0);
        do_cmd(0, 0, 0, 0,   0, 0, 1, 0, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
